// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and default beat width for the icache hold buffer.
package icache_pkg;
  typedef enum logic [1:0] {
    ICACHE_HOLD_EMPTY   = 2'b00,
    ICACHE_HOLD_PARTIAL = 2'b01,
    ICACHE_HOLD_FULL    = 2'b10
  } icache_hold_state_e;
  localparam int ICACHE_DATA_WIDTH = 32;
endpackage

// File: rtl/icache_hold_mem.sv
// icache_hold_mem: DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read, no reset.
module icache_hold_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clock) if (wr_en) mem_q[wr_idx] <= wr_data;
  assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/icache_data_hold_fifo.sv
// icache_data_hold_fifo: DEPTH-entry elastic buffer between icache data read and fetch, with flush.
// Define ICACHE_HOLD_BYPASS_EN for zero-latency pass-through when the buffer is empty.
module icache_data_hold_fifo
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  icache_hold_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic stored_valid, bypass, push, pop, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  assign stored_valid = state_q != ICACHE_HOLD_EMPTY;
`ifdef ICACHE_HOLD_BYPASS_EN
  assign bypass = ~stored_valid & ~flush & reset;
`else
  assign bypass = 1'b0;
`endif
  assign in_ready  = state_q != ICACHE_HOLD_FULL;
  assign out_valid = bypass ? in_valid : stored_valid;
  assign out_data  = bypass ? (in_valid ? in_data : '0) : (stored_valid ? rd_data : '0);
  assign count     = count_q;
  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  // a bypassed beat that the consumer takes immediately is never stored
  assign wr_en = push & ~flush & ~(bypass & pop);
  assign rd_en = pop & ~bypass & ~flush;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    state_d = (count_d == '0) ? ICACHE_HOLD_EMPTY :
              (count_d == FULL_CNT) ? ICACHE_HOLD_FULL : ICACHE_HOLD_PARTIAL;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ICACHE_HOLD_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end
  icache_hold_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_idx  (wr_ptr_q),
    .wr_data (in_data),
    .rd_idx  (rd_ptr_q),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_icache_data_hold_fifo.sv
// tb_icache_data_hold_fifo: directed checks on a DEPTH=2 and a DEPTH=4 instance, either bypass mode.
module tb_icache_data_hold_fifo;
`ifdef ICACHE_HOLD_BYPASS_EN
  localparam logic       BYP        = 1'b1;
  localparam logic [1:0] STREAM_CNT = 2'd0;
`else
  localparam logic       BYP        = 1'b0;
  localparam logic [1:0] STREAM_CNT = 2'd1;
`endif
  logic clock = 1'b0;
  logic reset, flush;
  logic iv2, ir2, ov2, or2, iv4, ir4, ov4, or4;
  logic [31:0] id2, od2, id4, od4;
  logic [1:0] cnt2;
  logic [2:0] cnt4;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  icache_data_hold_fifo #(.DATA_WIDTH(32), .DEPTH(2)) u2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
  );
  icache_data_hold_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u4 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .count(cnt4)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("cnt2 bound", 64'(cnt2 <= 2'd2), 64'd1);
      chk("cnt4 bound", 64'(cnt4 <= 3'd4), 64'd1);
    end
  end
  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_bp [4];
    int nxt, sent, got, cyc;
    reset = 1'b0; flush = 1'b0;
    iv2 = 1'b1; id2 = 32'hDEADBEEF; or2 = 1'b0;
    iv4 = 1'b1; id4 = 32'hDEADBEEF; or4 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst ov2", ov2, 0);
      chk("rst od2", od2, 0);
      chk("rst cnt2", cnt2, 0);
      chk("rst ir2", ir2, 1);
      chk("rst ov4", ov4, 0);
    end
    reset = 1'b1; iv2 = 1'b0; iv4 = 1'b0;
    tick();
    chk("post rst ov2", ov2, 0);
    chk("post rst cnt2", cnt2, 0);
    chk("post rst ir2", ir2, 1);
    iv2 = 1'b1; id2 = 32'h11;
    tick();
    id2 = 32'h22;
    tick();
    iv2 = 1'b0;
    #1;
    chk("fill cnt2", cnt2, 2);
    chk("fill ir2", ir2, 0);
    chk("fill ov2", ov2, 1);
    chk("fill od2", od2, 32'h11);
    or2 = 1'b1;
    tick();
    chk("drain od2 second", od2, 32'h22);
    chk("drain cnt2 mid", cnt2, 1);
    tick();
    chk("drain cnt2 end", cnt2, 0);
    chk("drain ov2 end", ov2, 0);
    chk("drain od2 end", od2, 0);
    nxt = 1;
    for (int i = 1; i <= 100; i++) begin
      iv2 = 1'b1; or2 = 1'b1; id2 = 32'(i);
      #1;
      if (i == 1) chk("stream latency", ov2, BYP);
      if (ov2) begin
        chk("stream data", od2, 64'(nxt));
        nxt++;
      end
      tick();
      chk("stream cnt", cnt2, STREAM_CNT);
    end
    iv2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ov2) begin
        chk("stream tail", od2, 64'(nxt));
        nxt++;
      end
      tick();
    end
    chk("stream total", nxt, 101);
    chk("stream empty", cnt2, 0);
    or2 = 1'b0;
    exp_bp[0] = 32'hBB; exp_bp[1] = 32'hCC; exp_bp[2] = 32'hDD; exp_bp[3] = 32'h55;
    iv4 = 1'b1; or4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id4 = 32'hAA + 32'(i) * 32'h11;
      tick();
    end
    chk("bp full cnt4", cnt4, 4);
    chk("bp full ir4", ir4, 0);
    id4 = 32'h55;
    for (int k = 0; k < 5; k++) begin
      or4 = (k == 3);
      #1;
      chk("bp ir4", ir4, (k == 4));
      if (k == 3) chk("bp first pop", od4, 32'hAA);
      tick();
    end
    iv4 = 1'b0; or4 = 1'b0;
    chk("bp refilled cnt4", cnt4, 4);
    or4 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("bp drain", od4, exp_bp[j]);
      tick();
    end
    chk("bp once ov4", ov4, 0);
    chk("bp once cnt4", cnt4, 0);
    or4 = 1'b0; iv4 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      id4 = 32'(i);
      tick();
    end
    chk("flush pre cnt4", cnt4, 3);
    id4 = 32'h77; or4 = 1'b1; flush = 1'b1;
    #1;
    chk("flush cycle ov4", ov4, 1);
    chk("flush cycle od4", od4, 1);
    tick();
    flush = 1'b0; iv4 = 1'b0;
    #1;
    chk("flush cnt4", cnt4, 0);
    chk("flush ov4", ov4, 0);
    chk("flush od4", od4, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush no 77", ov4, 0);
    end
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      iv4 = (sent < 1000) && ($urandom_range(0, 1) == 1);
      id4 = 32'(sent + 1);
      or4 = ($urandom_range(0, 1) == 1);
      #1;
      if (iv4 && ir4) begin
        q.push_back(id4);
        sent++;
      end
      if (ov4 && or4) begin
        if (q.size() == 0) chk("rand spurious", ov4, 0);
        else chk("rand data", od4, q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    chk("rand got", got, 1000);
    iv4 = 1'b1; or4 = 1'b0;
    id4 = 32'hA1;
    tick();
    id4 = 32'hA2;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; iv4 = 1'b0;
    #1;
    chk("midrst cnt4", cnt4, 0);
    chk("midrst ov4", ov4, 0);
    chk("midrst od4", od4, 0);
    tick();
    chk("midrst stays empty", ov4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
